// File: rtl/banked_data_memory.sv
// rtl/banked_data_memory.sv - byte-banked data memory with unaligned, wrapping loads and stores
//
// Purpose:
//   A 2^ADDR_WIDTH-byte memory split across NUM_BANKS byte-wide banks.
//   Address bits [BANK_BITS-1:0] select the bank and the upper bits select the row.
//   Each bank has its own row address, so any access whose length fits in
//   NUM_BANKS bytes finishes in a single beat, whatever its alignment.
//   Longer accesses take ceil(L/NUM_BANKS) beats.
//
// Ports:
//   clk         : clock; all state changes on the rising edge
//   reset       : asynchronous active-high reset (bank contents are kept)
//   req_valid   : a request is presented
//   req_ready   : the block can accept a request (high only in IDLE)
//   req_write   : 1 = store, 0 = load
//   req_size    : 0 byte, 1 halfword, 2 word, 3 illegal
//   req_signed  : sign-extend load data when 1, zero-extend when 0
//   req_addr    : byte address; any alignment; wraps at the top of memory
//   req_wdata   : store data, little-endian from the low byte
//   rsp_valid   : one-cycle completion pulse
//   rsp_rdata   : extended load data (0 for stores and errors), held between responses
//   rsp_error   : the completed request had an illegal size
module banked_data_memory #(
  parameter int ADDR_WIDTH = 9,
  parameter int NUM_BANKS  = 2
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  req_valid,
  output logic                  req_ready,
  input  logic                  req_write,
  input  logic [1:0]            req_size,
  input  logic                  req_signed,
  input  logic [ADDR_WIDTH-1:0] req_addr,
  input  logic [31:0]           req_wdata,
  output logic                  rsp_valid,
  output logic [31:0]           rsp_rdata,
  output logic                  rsp_error
);

  localparam int BANK_BITS  = $clog2(NUM_BANKS);
  localparam int BANK_DEPTH = (2 ** ADDR_WIDTH) / NUM_BANKS;
  localparam int ROW_WIDTH  = ADDR_WIDTH - BANK_BITS;

  generate
    if (NUM_BANKS != 1 && NUM_BANKS != 2 && NUM_BANKS != 4) begin : gBadNumBanks
      $error("banked_data_memory: NUM_BANKS must be 1, 2 or 4");
    end
  endgenerate

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    BEAT = 2'd1,
    RESP = 2'd2
  } stateT;

  stateT      state;
  stateT      nextState;
  logic [1:0] beatCnt;
  logic [1:0] nextBeatCnt;

  // Request fields captured at acceptance; inputs are ignored afterwards.
  logic                  reqWriteQ;
  logic                  reqSignedQ;
  logic [1:0]            reqSizeQ;
  logic [ADDR_WIDTH-1:0] reqAddrQ;
  logic [31:0]           reqWdataQ;

  logic [2:0] accessLen;
  logic [2:0] beatTotal;
  logic [1:0] lastBeat;
  logic       accept;

  // Per-bank lane control for the current beat.
  logic [NUM_BANKS-1:0]                laneOn;
  logic [NUM_BANKS-1:0]                laneWe;
  logic [NUM_BANKS-1:0]                laneRd;
  logic [NUM_BANKS-1:0][2:0]           laneIdx;
  logic [NUM_BANKS-1:0][ROW_WIDTH-1:0] laneRow;
  logic [NUM_BANKS-1:0][7:0]           laneWdata;

  // Read lanes delayed by the one-cycle bank read latency.
  logic [NUM_BANKS-1:0]      laneRdQ;
  logic [NUM_BANKS-1:0][2:0] laneIdxQ;
  logic [NUM_BANKS-1:0][7:0] bankRdata;

  logic [31:0] assembly;
  logic [31:0] mergedData;
  logic [31:0] result;
  logic [31:0] rspHold;

  assign accept = req_valid && (state == IDLE);

  // Access length and beat count follow the captured size; size 3 never
  // reaches BEAT, so its length value is irrelevant.
  always_comb begin
    case (reqSizeQ)
      2'd0:    accessLen = 3'd1;
      2'd1:    accessLen = 3'd2;
      default: accessLen = 3'd4;
    endcase
    beatTotal = 3'((int'(accessLen) + NUM_BANKS - 1) / NUM_BANKS);
    lastBeat  = 2'(beatTotal - 3'd1);
  end

  // FSM: state register
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state   <= IDLE;
      beatCnt <= 2'd0;
    end else begin
      state   <= nextState;
      beatCnt <= nextBeatCnt;
    end
  end

  // FSM: next state and handshake/response outputs
  always_comb begin
    nextState   = state;
    nextBeatCnt = beatCnt;
    req_ready   = 1'b0;
    rsp_valid   = 1'b0;
    rsp_error   = 1'b0;
    rsp_rdata   = rspHold;
    case (state)
      IDLE: begin
        req_ready   = 1'b1;
        nextBeatCnt = 2'd0;
        if (req_valid) begin
          nextState = (req_size == 2'd3) ? RESP : BEAT;
        end
      end
      BEAT: begin
        if (beatCnt == lastBeat) begin
          nextState   = RESP;
          nextBeatCnt = 2'd0;
        end else begin
          nextBeatCnt = beatCnt + 2'd1;
        end
      end
      RESP: begin
        rsp_valid = 1'b1;
        rsp_error = (reqSizeQ == 2'd3);
        rsp_rdata = result;
        nextState = IDLE;
      end
      default: begin
        nextState = IDLE;
      end
    endcase
  end

  // Lane mapping. In beat k, bank b holds byte i = k*NUM_BANKS + ((b - addr) mod NUM_BANKS):
  // consecutive bytes rotate across banks starting at the bank of the base address.
  // The byte is present only when i < L. Its row comes from the full wrapped byte address,
  // so a row crossing inside a beat simply gives neighbouring banks different rows.
  always_comb begin
    for (int b = 0; b < NUM_BANKS; b++) begin
      laneIdx[b]   = 3'((int'(beatCnt) * NUM_BANKS) + ((b - int'(reqAddrQ)) & (NUM_BANKS - 1)));
      laneRow[b]   = ROW_WIDTH'((reqAddrQ + ADDR_WIDTH'(laneIdx[b])) >> BANK_BITS);
      laneOn[b]    = (state == BEAT) && (laneIdx[b] < accessLen);
      laneWe[b]    = laneOn[b] && reqWriteQ;
      laneRd[b]    = laneOn[b] && !reqWriteQ;
      laneWdata[b] = reqWdataQ[8*laneIdx[b] +: 8];
    end
  end

  // Byte-wide banks with registered read data; no reset so contents survive reset.
  for (genvar b = 0; b < NUM_BANKS; b++) begin : gBank
    logic [7:0] mem [BANK_DEPTH];
    logic [7:0] rdByte;

    always_ff @(posedge clk) begin
      if (laneWe[b]) begin
        mem[laneRow[b]] <= laneWdata[b];
      end
      if (laneRd[b]) begin
        rdByte <= mem[laneRow[b]];
      end
    end

    assign bankRdata[b] = rdByte;
  end

  // Bytes returning from the previous beat are dropped into their slots. This
  // runs every cycle, so the final beat lands combinationally during RESP.
  always_comb begin
    mergedData = assembly;
    for (int b = 0; b < NUM_BANKS; b++) begin
      if (laneRdQ[b]) begin
        mergedData[8*laneIdxQ[b] +: 8] = bankRdata[b];
      end
    end
  end

  // Extension from bit 8L-1; stores and illegal requests return zero.
  always_comb begin
    result = 32'd0;
    if (!reqWriteQ) begin
      case (reqSizeQ)
        2'd0:    result = {{24{reqSignedQ & mergedData[7]}}, mergedData[7:0]};
        2'd1:    result = {{16{reqSignedQ & mergedData[15]}}, mergedData[15:0]};
        2'd2:    result = mergedData;
        default: result = 32'd0;
      endcase
    end
  end

  // Request capture, read assembly and response hold register.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      reqWriteQ  <= 1'b0;
      reqSignedQ <= 1'b0;
      reqSizeQ   <= 2'd0;
      reqAddrQ   <= '0;
      reqWdataQ  <= 32'd0;
      laneRdQ    <= '0;
      laneIdxQ   <= '0;
      assembly   <= 32'd0;
      rspHold    <= 32'd0;
    end else begin
      laneRdQ  <= laneRd;
      laneIdxQ <= laneIdx;
      if (accept) begin
        reqWriteQ  <= req_write;
        reqSignedQ <= req_signed;
        reqSizeQ   <= req_size;
        reqAddrQ   <= req_addr;
        reqWdataQ  <= req_wdata;
        assembly   <= 32'd0;
      end else begin
        assembly <= mergedData;
      end
      if (state == RESP) begin
        rspHold <= result;
      end
    end
  end

endmodule

// File: tb/tb_banked_data_memory.sv
// tb/tb_banked_data_memory.sv - directed self-checking bench for banked_data_memory
module tb_banked_data_memory;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  int checks   = 0;
  int failures = 0;

  // Instance A: default two banks
  logic        resetA;
  logic        reqValidA;
  logic        reqReadyA;
  logic        reqWriteA;
  logic [1:0]  reqSizeA;
  logic        reqSignedA;
  logic [8:0]  reqAddrA;
  logic [31:0] reqWdataA;
  logic        rspValidA;
  logic [31:0] rspRdataA;
  logic        rspErrorA;

  // Instance B: one bank
  logic        resetB;
  logic        reqValidB;
  logic        reqReadyB;
  logic        reqWriteB;
  logic [1:0]  reqSizeB;
  logic        reqSignedB;
  logic [8:0]  reqAddrB;
  logic [31:0] reqWdataB;
  logic        rspValidB;
  logic [31:0] rspRdataB;
  logic        rspErrorB;

  banked_data_memory #(.ADDR_WIDTH(9), .NUM_BANKS(2)) dutA (
    .clk(clk), .reset(resetA),
    .req_valid(reqValidA), .req_ready(reqReadyA), .req_write(reqWriteA),
    .req_size(reqSizeA), .req_signed(reqSignedA), .req_addr(reqAddrA),
    .req_wdata(reqWdataA), .rsp_valid(rspValidA), .rsp_rdata(rspRdataA),
    .rsp_error(rspErrorA)
  );

  banked_data_memory #(.ADDR_WIDTH(9), .NUM_BANKS(1)) dutB (
    .clk(clk), .reset(resetB),
    .req_valid(reqValidB), .req_ready(reqReadyB), .req_write(reqWriteB),
    .req_size(reqSizeB), .req_signed(reqSignedB), .req_addr(reqAddrB),
    .req_wdata(reqWdataB), .rsp_valid(rspValidB), .rsp_rdata(rspRdataB),
    .rsp_error(rspErrorB)
  );

  // Issue one request on A; latency counts clock cycles from acceptance to the
  // cycle carrying rsp_valid (0 when no response arrives within the bound).
  task automatic reqA(input bit aligned, input logic w, input logic [1:0] sz,
                      input logic sg, input logic [8:0] a, input logic [31:0] wd,
                      output logic [31:0] rd, output logic er, output int lat);
    if (!aligned) @(negedge clk);
    reqValidA = 1'b1; reqWriteA = w; reqSizeA = sz; reqSignedA = sg;
    reqAddrA = a; reqWdataA = wd;
    @(posedge clk);
    #1;
    reqValidA = 1'b0; reqWriteA = ~w; reqSizeA = ~sz; reqSignedA = ~sg;
    reqAddrA = ~a; reqWdataA = ~wd;
    rd = 'x; er = 1'bx; lat = 0;
    for (int i = 1; i <= 10; i++) begin
      @(negedge clk);
      if (rspValidA) begin
        lat = i; rd = rspRdataA; er = rspErrorA;
        break;
      end
    end
  endtask

  task automatic reqB(input logic w, input logic [1:0] sz, input logic sg,
                      input logic [8:0] a, input logic [31:0] wd,
                      output logic [31:0] rd, output logic er, output int lat);
    @(negedge clk);
    reqValidB = 1'b1; reqWriteB = w; reqSizeB = sz; reqSignedB = sg;
    reqAddrB = a; reqWdataB = wd;
    @(posedge clk);
    #1;
    reqValidB = 1'b0; reqWriteB = ~w; reqSizeB = ~sz; reqSignedB = ~sg;
    reqAddrB = ~a; reqWdataB = ~wd;
    rd = 'x; er = 1'bx; lat = 0;
    for (int i = 1; i <= 10; i++) begin
      @(negedge clk);
      if (rspValidB) begin
        lat = i; rd = rspRdataB; er = rspErrorB;
        break;
      end
    end
  endtask

  task automatic test_reset();
    resetA = 1'b1; resetB = 1'b1;
    reqValidA = 1'b0; reqWriteA = 1'b0; reqSizeA = 2'd0; reqSignedA = 1'b0;
    reqAddrA = '0; reqWdataA = '0;
    reqValidB = 1'b0; reqWriteB = 1'b0; reqSizeB = 2'd0; reqSignedB = 1'b0;
    reqAddrB = '0; reqWdataB = '0;
    #12;
    checks++; if (reqReadyA !== 1'b1) begin failures++; $display("FAIL reset_ready got=%b exp=1", reqReadyA); end
    checks++; if (rspValidA !== 1'b0) begin failures++; $display("FAIL reset_rsp_valid got=%b exp=0", rspValidA); end
    checks++; if (rspErrorA !== 1'b0) begin failures++; $display("FAIL reset_rsp_error got=%b exp=0", rspErrorA); end
    checks++; if (rspRdataA !== 32'd0) begin failures++; $display("FAIL reset_rsp_rdata got=%h exp=00000000", rspRdataA); end
    checks++; if (reqReadyB !== 1'b1) begin failures++; $display("FAIL reset_ready_b got=%b exp=1", reqReadyB); end
    @(negedge clk);
    resetA = 1'b0; resetB = 1'b0;
  endtask

  task automatic test_unaligned_word();
    logic [31:0] rd; logic er; int lat;
    reqA(0, 1'b1, 2'd2, 1'b0, 9'h003, 32'hDEADBEEF, rd, er, lat);
    checks++; if (lat !== 3) begin failures++; $display("FAIL uw_store_latency got=%0d exp=3", lat); end
    checks++; if (rd !== 32'd0 || er !== 1'b0) begin failures++; $display("FAIL uw_store_rsp got=%h/%b exp=00000000/0", rd, er); end
    reqA(0, 1'b0, 2'd2, 1'b0, 9'h003, 32'h0, rd, er, lat);
    checks++; if (lat !== 3) begin failures++; $display("FAIL uw_load_latency got=%0d exp=3", lat); end
    checks++; if (rd !== 32'hDEADBEEF) begin failures++; $display("FAIL uw_load_data got=%h exp=deadbeef", rd); end
    reqA(0, 1'b0, 2'd0, 1'b0, 9'h004, 32'h0, rd, er, lat);
    checks++; if (lat !== 2) begin failures++; $display("FAIL uw_byte_latency got=%0d exp=2", lat); end
    checks++; if (rd !== 32'h000000BE) begin failures++; $display("FAIL uw_byte4 got=%h exp=000000be", rd); end
    reqA(0, 1'b0, 2'd0, 1'b1, 9'h006, 32'h0, rd, er, lat);
    checks++; if (rd !== 32'hFFFFFFDE) begin failures++; $display("FAIL uw_byte6_signed got=%h exp=ffffffde", rd); end
  endtask

  task automatic test_extension();
    logic [31:0] rd; logic er; int lat;
    reqA(0, 1'b1, 2'd0, 1'b0, 9'h011, 32'h0, rd, er, lat);
    reqA(0, 1'b1, 2'd0, 1'b0, 9'h010, 32'h12345680, rd, er, lat);
    checks++; if (lat !== 2) begin failures++; $display("FAIL ext_store_latency got=%0d exp=2", lat); end
    reqA(0, 1'b0, 2'd0, 1'b1, 9'h010, 32'h0, rd, er, lat);
    checks++; if (rd !== 32'hFFFFFF80) begin failures++; $display("FAIL ext_signed_byte got=%h exp=ffffff80", rd); end
    reqA(0, 1'b0, 2'd0, 1'b0, 9'h010, 32'h0, rd, er, lat);
    checks++; if (rd !== 32'h00000080) begin failures++; $display("FAIL ext_unsigned_byte got=%h exp=00000080", rd); end
    reqA(0, 1'b0, 2'd1, 1'b1, 9'h010, 32'h0, rd, er, lat);
    checks++; if (rd !== 32'h00000080) begin failures++; $display("FAIL ext_signed_half got=%h exp=00000080", rd); end
  endtask

  task automatic test_wrap();
    logic [31:0] rd; logic er; int lat;
    reqA(0, 1'b1, 2'd1, 1'b0, 9'h1FF, 32'h0000A5C3, rd, er, lat);
    checks++; if (lat !== 2) begin failures++; $display("FAIL wrap_store_latency got=%0d exp=2", lat); end
    reqA(0, 1'b0, 2'd0, 1'b0, 9'h1FF, 32'h0, rd, er, lat);
    checks++; if (rd !== 32'h000000C3) begin failures++; $display("FAIL wrap_byte_1ff got=%h exp=000000c3", rd); end
    reqA(0, 1'b0, 2'd0, 1'b0, 9'h000, 32'h0, rd, er, lat);
    checks++; if (rd !== 32'h000000A5) begin failures++; $display("FAIL wrap_byte_000 got=%h exp=000000a5", rd); end
    reqA(0, 1'b0, 2'd1, 1'b0, 9'h1FF, 32'h0, rd, er, lat);
    checks++; if (rd !== 32'h0000A5C3) begin failures++; $display("FAIL wrap_half_unsigned got=%h exp=0000a5c3", rd); end
    reqA(0, 1'b0, 2'd1, 1'b1, 9'h1FF, 32'h0, rd, er, lat);
    checks++; if (rd !== 32'hFFFFA5C3) begin failures++; $display("FAIL wrap_half_signed got=%h exp=ffffa5c3", rd); end
  endtask

  task automatic test_illegal();
    logic [31:0] rd; logic er; int lat;
    reqA(0, 1'b1, 2'd0, 1'b0, 9'h020, 32'h0000005A, rd, er, lat);
    reqA(0, 1'b1, 2'd3, 1'b0, 9'h020, 32'hFFFFFFFF, rd, er, lat);
    checks++; if (lat !== 1) begin failures++; $display("FAIL illegal_latency got=%0d exp=1", lat); end
    checks++; if (er !== 1'b1) begin failures++; $display("FAIL illegal_error got=%b exp=1", er); end
    checks++; if (rd !== 32'd0) begin failures++; $display("FAIL illegal_rdata got=%h exp=00000000", rd); end
    reqA(0, 1'b0, 2'd0, 1'b0, 9'h020, 32'h0, rd, er, lat);
    checks++; if (rd !== 32'h0000005A) begin failures++; $display("FAIL illegal_no_write got=%h exp=0000005a", rd); end
    checks++; if (er !== 1'b0) begin failures++; $display("FAIL legal_error got=%b exp=0", er); end
  endtask

  task automatic test_back_to_back();
    @(negedge clk);
    reqValidA = 1'b1; reqWriteA = 1'b0; reqSizeA = 2'd0; reqSignedA = 1'b0;
    reqAddrA = 9'h020;
    @(posedge clk);
    #1;
    reqAddrA = 9'h1FF;
    @(negedge clk);
    checks++; if (reqReadyA !== 1'b0) begin failures++; $display("FAIL b2b_ready_beat got=%b exp=0", reqReadyA); end
    @(negedge clk);
    checks++; if (rspValidA !== 1'b1 || rspRdataA !== 32'h0000005A) begin failures++; $display("FAIL b2b_first_rsp got=%b/%h exp=1/0000005a", rspValidA, rspRdataA); end
    checks++; if (reqReadyA !== 1'b0) begin failures++; $display("FAIL b2b_ready_resp got=%b exp=0", reqReadyA); end
    @(negedge clk);
    checks++; if (reqReadyA !== 1'b1 || rspValidA !== 1'b0) begin failures++; $display("FAIL b2b_idle got=%b/%b exp=1/0", reqReadyA, rspValidA); end
    checks++; if (rspRdataA !== 32'h0000005A) begin failures++; $display("FAIL b2b_hold got=%h exp=0000005a", rspRdataA); end
    @(posedge clk);
    #1;
    reqValidA = 1'b0;
    @(negedge clk);
    @(negedge clk);
    checks++; if (rspValidA !== 1'b1 || rspRdataA !== 32'h000000C3) begin failures++; $display("FAIL b2b_second_rsp got=%b/%h exp=1/000000c3", rspValidA, rspRdataA); end
  endtask

  task automatic test_async_reset();
    logic [31:0] rd; logic er; int lat;
    @(negedge clk);
    reqValidA = 1'b1; reqWriteA = 1'b0; reqSizeA = 2'd2; reqAddrA = 9'h003;
    @(posedge clk);
    #1;
    reqValidA = 1'b0;
    #2;
    checks++; if (reqReadyA !== 1'b0 || rspRdataA !== 32'h000000C3) begin failures++; $display("FAIL areset_pre got=%b/%h exp=0/000000c3", reqReadyA, rspRdataA); end
    resetA = 1'b1;
    #1;
    checks++; if (reqReadyA !== 1'b1 || rspValidA !== 1'b0 || rspErrorA !== 1'b0) begin failures++; $display("FAIL areset_ctrl got=%b/%b/%b exp=1/0/0", reqReadyA, rspValidA, rspErrorA); end
    checks++; if (rspRdataA !== 32'd0) begin failures++; $display("FAIL areset_rdata got=%h exp=00000000", rspRdataA); end
    @(negedge clk);
    @(negedge clk);
    resetA = 1'b0;
    reqA(1, 1'b0, 2'd0, 1'b0, 9'h004, 32'h0, rd, er, lat);
    checks++; if (lat !== 2 || rd !== 32'h000000BE) begin failures++; $display("FAIL areset_first_accept got=%0d/%h exp=2/000000be", lat, rd); end
  endtask

  task automatic test_mid_op_reset();
    logic [31:0] rd; logic er; int lat;
    logic [7:0] expBytes [4];
    expBytes[0] = 8'h44; expBytes[1] = 8'h33; expBytes[2] = 8'h00; expBytes[3] = 8'h00;
    reqB(1'b1, 2'd2, 1'b0, 9'h040, 32'h0, rd, er, lat);
    checks++; if (lat !== 5) begin failures++; $display("FAIL b1_word_latency got=%0d exp=5", lat); end
    @(negedge clk);
    reqValidB = 1'b1; reqWriteB = 1'b1; reqSizeB = 2'd2; reqSignedB = 1'b0;
    reqAddrB = 9'h040; reqWdataB = 32'h11223344;
    @(posedge clk);
    #1;
    reqValidB = 1'b0;
    @(posedge clk);
    @(posedge clk);
    #3;
    resetB = 1'b1;
    #1;
    checks++; if (reqReadyB !== 1'b1 || rspValidB !== 1'b0) begin failures++; $display("FAIL b1_reset_ctrl got=%b/%b exp=1/0", reqReadyB, rspValidB); end
    @(negedge clk);
    resetB = 1'b0;
    for (int i = 0; i < 4; i++) begin
      reqB(1'b0, 2'd0, 1'b0, 9'(9'h040 + i), 32'h0, rd, er, lat);
      checks++;
      if (lat !== 2 || rd !== {24'd0, expBytes[i]}) begin
        failures++;
        $display("FAIL b1_byte%0d got=%0d/%h exp=2/%h", i, lat, rd, {24'd0, expBytes[i]});
      end
    end
    reqB(1'b0, 2'd2, 1'b0, 9'h040, 32'h0, rd, er, lat);
    checks++; if (rd !== 32'h00003344) begin failures++; $display("FAIL b1_word_after got=%h exp=00003344", rd); end
  endtask

  initial begin
    test_reset();
    test_unaligned_word();
    test_extension();
    test_wrap();
    test_illegal();
    test_back_to_back();
    test_async_reset();
    test_mid_op_reset();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/banked_data_memory.md
BANKED_DATA_MEMORY -- requirements
Module: banked_data_memory

Interface
REQ-001 SHALL have parameter ADDR_WIDTH, default 9, giving the byte-address width; memory size is 2^ADDR_WIDTH bytes.
REQ-002 SHALL have parameter NUM_BANKS, default 2, giving the number of byte-wide banks; legal values are 1, 2 and 4, and any other value fails elaboration.
REQ-003 SHALL derive BANK_DEPTH = 2^ADDR_WIDTH / NUM_BANKS rows per bank.
REQ-004 SHALL have port clk, input, 1 bit: the single clock; all state updates on its rising edge.
REQ-005 SHALL have port reset, input, 1 bit: asynchronous, active-high reset.
REQ-006 SHALL have port req_valid, input, 1 bit: a request is presented.
REQ-007 SHALL have port req_ready, output, 1 bit: the block can accept a request.
REQ-008 SHALL have port req_write, input, 1 bit: 1 = store, 0 = load.
REQ-009 SHALL have port req_size, input, 2 bits: 0 = byte, 1 = halfword, 2 = word, 3 = illegal.
REQ-010 SHALL have port req_signed, input, 1 bit: a load is sign-extended when 1 and zero-extended when 0.
REQ-011 SHALL have port req_addr, input, ADDR_WIDTH bits: byte address, with no alignment requirement.
REQ-012 SHALL have port req_wdata, input, 32 bits: store data, taken from the low bytes.
REQ-013 SHALL have port rsp_valid, output, 1 bit: a one-cycle completion pulse.
REQ-014 SHALL have port rsp_rdata, output, 32 bits: extended load data; 0 for stores and errors.
REQ-015 SHALL have port rsp_error, output, 1 bit: the completed request was illegal.

Function
REQ-016 SHALL accept a request on a rising edge where req_valid and req_ready are both 1, and SHALL register all request fields at that edge; later input changes SHALL be ignored.
REQ-017 SHALL implement the FSM states IDLE, BEAT and RESP; req_ready = 1 only in IDLE.
REQ-018 SHALL move IDLE->BEAT on a legal acceptance and IDLE->RESP on an acceptance with req_size = 3.
REQ-019 SHALL set the access length L = 1, 2 or 4 bytes and the beat count B = ceil(L/NUM_BANKS); a beat counter SHALL run 0..B-1 in BEAT, one beat per cycle, followed by BEAT->RESP.
REQ-020 SHALL map byte i of an access (0 <= i < L) to address A_i = (req_addr + i) mod 2^ADDR_WIDTH, bank A_i mod NUM_BANKS, row A_i / NUM_BANKS, in beat i / NUM_BANKS.
REQ-021 SHALL give every bank an independent row address, so unaligned accesses and row crossings complete in a single beat whenever L <= NUM_BANKS.
REQ-022 SHALL use little-endian ordering: byte i is req_wdata[8i+7:8i] and occupies rsp_rdata[8i+7:8i] before extension.
REQ-023 SHALL write store bytes in their beat cycle and SHALL NOT write any bank whose byte is absent in that beat.
REQ-024 SHALL use synchronous-read banks with a one-cycle read latency; returned bytes SHALL be captured into an assembly register, and the last beat's bytes SHALL be merged in RESP.
REQ-025 SHALL stay in RESP for exactly 1 cycle with rsp_valid = 1, then return to IDLE; req_ready SHALL be 0 in RESP.
REQ-026 SHALL give a legal request a total latency from the acceptance edge to rsp_valid of B+1 cycles, and an illegal request a latency of 1 cycle.
REQ-027 SHALL, for loads, extend from bit 8L-1 when req_signed = 1 and zero-fill above bit 8L-1 otherwise.
REQ-028 SHALL, for size 3, perform no bank access and return rsp_error = 1 with rsp_rdata = 0; rsp_error SHALL be 0 for every legal request.
REQ-029 SHALL accept back-to-back requests, with the next acceptance possible in the cycle after RESP.
REQ-030 SHALL keep rsp_valid, rsp_rdata and rsp_error stable outside RESP: rsp_valid = 0, rsp_error = 0, and rsp_rdata holding its last value.

Reset
REQ-031 SHALL, while reset = 1, immediately force FSM = IDLE, beat counter = 0, req_ready = 1, rsp_valid = 0, rsp_error = 0 and rsp_rdata = 0.
REQ-032 SHALL NOT clear bank contents on reset; beats already written before a mid-operation reset remain committed, and no later beat of that request executes.
REQ-033 SHALL make the first acceptance possible on the first rising edge after reset deasserts.

Verification
REQ-034 SHALL cover this reset scenario: assert reset asynchronously mid-cycle -> outputs reach the REQ-031 values immediately, without waiting for a clock edge.
REQ-035 SHALL cover this unaligned-word scenario: NUM_BANKS = 2, store word 0xDEADBEEF @0x003, then unsigned word load @0x003 -> each rsp_valid exactly 3 cycles after acceptance, rsp_rdata = 0xDEADBEEF, and byte load @0x004 = 0x000000BE.
REQ-036 SHALL cover this extension scenario: store byte 0x80 @0x010 -> signed byte load = 0xFFFFFF80, unsigned byte load = 0x00000080, and signed halfword load @0x010 with 0x011 = 0x00 -> 0x00000080.
REQ-037 SHALL cover this wrap scenario: store halfword 0xA5C3 @0x1FF -> byte @0x1FF = 0xC3 and byte @0x000 = 0xA5; unsigned halfword load @0x1FF = 0x0000A5C3.
REQ-038 SHALL cover this illegal-size scenario: req_size = 3 store @0x020 -> rsp_valid and rsp_error pulse 1 cycle after acceptance, and a subsequent byte load @0x020 returns the prior contents unchanged.
REQ-039 SHALL cover this mid-operation reset scenario: NUM_BANKS = 1, store word 0x11223344 @0x040 over memory preset to 0, with reset asserted during beat 2 -> after reset, byte loads @0x040..0x043 return 0x44, 0x33, 0x00, 0x00 and req_ready = 1.
